main_memory: RTL and testbench

Backing-store RAM with a configurable multi-cycle access latency. It sits directly downstream of the cache and serves its write-through writes and read-miss fills over the `data`/`addr`/`wr` → `response`/`out` interface. A request is signalled by any change of the inputs, and `response` reports completion. The block replaces the zero-wait behavioural memory so that the cache's miss path and `response` waiting can be exercised at realistic latencies.

---
 rtl/main_memory.sv | 89 ++++++++
 tb/tb_main_memory.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// rtl/main_memory.sv - backing-store RAM with configurable multi-cycle access latency
module main_memory #(
  parameter int ADDR_BITS     = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);

  localparam logic [7:0] READ_CNT_INIT  = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WRITE_CNT_INIT = 8'(WRITE_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [7:0]  cnt;
  logic        accept;
  logic        done;

  logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: any input differing from the latched copy is a new request;
  // the access completes on the edge where the countdown has reached zero.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if ((data != data_q) || (addr != addr_q) || (wr != wr_q)) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latching, latency countdown, response and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'd0;
      addr_q   <= 32'd0;
      wr_q     <= 1'b0;
      cnt      <= 8'd0;
      response <= 1'b1;
      out      <= 32'd0;
    end else if (accept) begin
      data_q   <= data;
      addr_q   <= addr;
      wr_q     <= wr;
      cnt      <= wr ? WRITE_CNT_INIT : READ_CNT_INIT;
      response <= 1'b0;
    end else if (done) begin
      if (!wr_q) out <= mem[addr_q[ADDR_BITS-1:0]];
      response <= 1'b1;
    end else if (state == BUSY) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Writes commit only at completion, so a reset mid-access leaves mem untouched.
  always_ff @(posedge clk) begin
    if (!rst && done && wr_q) mem[addr_q[ADDR_BITS-1:0]] <= data_q;
  end

endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - self-checking bench for main_memory
module tb_main_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data, addr;
  logic        wr;
  logic        response;
  logic [31:0] out;

  logic [31:0] d1_data, d1_addr;
  logic        d1_wr;
  logic        d1_response;
  logic [31:0] d1_out;

  int checks = 0;
  int errors = 0;

  // reference model: memory image, last completed read data, latched request
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_out;
  logic [31:0] lat_d, lat_a;
  logic        lat_w;

  always #5 clk = ~clk;

  main_memory #(.ADDR_BITS(10), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
    .response(response), .out(out)
  );

  main_memory #(.ADDR_BITS(10), .READ_LATENCY(1), .WRITE_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .data(d1_data), .addr(d1_addr), .wr(d1_wr),
    .response(d1_response), .out(d1_out)
  );

  // Drive one access (called at a negedge), count low-response cycles, check result.
  task automatic do_access(input logic [31:0] d, input logic [31:0] a, input logic w,
                           input int lat, input string name);
    int n;
    data = d; addr = a; wr = w;
    @(negedge clk);
    n = 0;
    while (response === 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (w) ref_mem[a[9:0]] = d;
    else   exp_out = ref_mem[a[9:0]];
    lat_d = d; lat_a = a; lat_w = w;
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, lat);
    end
    checks++;
    if (out !== exp_out) begin
      errors++;
      $display("FAIL %s out: got %h want %h", name, out, exp_out);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data = 0; addr = 0; wr = 0;
    d1_data = 0; d1_addr = 0; d1_wr = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (response !== 1'b1 || out !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: response=%b out=%h want 1/0", i, response, out);
      end
      checks++;
      if (d1_response !== 1'b1 || d1_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle_l1 cycle %0d: response=%b out=%h want 1/0", i, d1_response, d1_out);
      end
    end
  endtask

  task automatic test_write_read;
    do_access(32'hDEADBEEF, 32'd5, 1'b1, 4, "write5");
    do_access(32'hDEADBEEF, 32'd5, 1'b0, 4, "read5");
  endtask

  task automatic test_alias;
    do_access(32'h11, 32'd3, 1'b1, 4, "write3");
    do_access(32'h0, 32'h403, 1'b0, 4, "read_alias403");
    do_access(32'h0, 32'd7, 1'b0, 4, "read7");
  endtask

  task automatic test_busy_change;
    int n;
    do_access(32'h66, 32'd6, 1'b1, 4, "write6");
    data = 0; addr = 5; wr = 0;
    @(negedge clk);
    checks++;
    if (response !== 1'b0) begin
      errors++;
      $display("FAIL busy_accept response: got %b want 0", response);
    end
    @(negedge clk);
    addr = 6;
    n = 2;
    @(negedge clk);
    while (response === 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    exp_out = ref_mem[5];
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL busy_first latency: got %0d want 4", n);
    end
    checks++;
    if (out !== exp_out) begin
      errors++;
      $display("FAIL busy_first out: got %h want %h", out, exp_out);
    end
    @(negedge clk);
    checks++;
    if (response !== 1'b0) begin
      errors++;
      $display("FAIL busy_second accept: response=%b want 0", response);
    end
    n = 1;
    @(negedge clk);
    while (response === 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    exp_out = ref_mem[6];
    lat_d = 0; lat_a = 6; lat_w = 0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL busy_second latency: got %0d want 4", n);
    end
    checks++;
    if (out !== exp_out) begin
      errors++;
      $display("FAIL busy_second out: got %h want %h", out, exp_out);
    end
  endtask

  task automatic test_latency1;
    int n;
    logic [31:0] vals [2] = '{32'hDEADBEEF, 32'h0};
    logic        ws   [2] = '{1'b1, 1'b0};
    int          lats [2] = '{2, 1};
    for (int k = 0; k < 2; k++) begin
      d1_data = vals[k]; d1_addr = 5; d1_wr = ws[k];
      @(negedge clk);
      n = 0;
      while (d1_response === 1'b0 && n < 300) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== lats[k]) begin
        errors++;
        $display("FAIL l1_access%0d latency: got %0d want %0d", k, n, lats[k]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d1_out !== 32'hDEADBEEF || d1_response !== 1'b1) begin
      errors++;
      $display("FAIL l1_read out=%h response=%b want deadbeef/1", d1_out, d1_response);
    end
  endtask

  task automatic test_random;
    logic [31:0] d, a;
    logic        w;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data = lat_d; addr = lat_a; wr = lat_w;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (response !== 1'b1 || out !== exp_out) begin
            errors++;
            $display("FAIL rand_repeat %0d: response=%b out=%h want 1/%h", i, response, out, exp_out);
          end
        end
      end else begin
        a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(16, 31));
        d = $urandom;
        w = 1'($urandom_range(0, 1));
        if (d == lat_d && a == lat_a && w == lat_w) d = ~d;
        do_access(d, a, w, 4, "rand_access");
      end
    end
  endtask

  task automatic test_reset_abort;
    int n;
    data = 32'hAA; addr = 9; wr = 1;
    @(negedge clk);
    checks++;
    if (response !== 1'b0) begin
      errors++;
      $display("FAIL abort_accept response: got %b want 0", response);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (response !== 1'b1 || out !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset response=%b out=%h want 1/0", response, out);
    end
    rst = 1'b0;
    data = 0; addr = 9; wr = 0;
    @(negedge clk);
    n = 0;
    while (response === 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL abort_read latency: got %0d want 4", n);
    end
    checks++;
    if (out !== ref_mem[9]) begin
      errors++;
      $display("FAIL abort_read out: got %h want %h", out, ref_mem[9]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    exp_out = 0; lat_d = 0; lat_a = 0; lat_w = 0;
    test_reset;
    test_write_read;
    test_alias;
    test_busy_change;
    test_latency1;
    test_random;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
